// File: rtl/window_sequencer_pkg.sv
// Shared types for the sliding-window sequencer: FSM states, window-buffer
// command encodings and the small modular-add helper used for row-cache slots.
package window_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_FILL_WR,
    ST_C_RD,
    ST_C_WAIT,
    ST_C_LOAD,
    ST_SD_REQ,
    ST_SD_WAIT,
    ST_SD_LOAD,
    ST_SHIFT,
    ST_EMIT,
    ST_ADV,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    WB_LOAD_CACHE = 2'd0,
    WB_LOAD_SD    = 2'd1,
    WB_SHIFT      = 2'd2
  } wb_mode_t;

  // Both operands are already below m, so one conditional subtract suffices.
  function automatic int wrap_add(input int a, input int b, input int m);
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/window_sequencer_counter.sv
// Up-counter with synchronous clear and wrap at MAX; rollover flags the terminal count.
module flex_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         rollover
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign rollover = (count == MAX_V);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= rollover ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/window_sequencer.sv
// Raster-order window sequencer: caches WIN-1 image rows, builds each WINxWIN
// window from cache plus one fresh SDRAM pixel, and hands windows to a consumer.
module window_sequencer
  import window_seq_pkg::*;
#(
  parameter int  IMG_W = 16,
  parameter int  IMG_H = 16,
  parameter int  WIN   = 3,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H),
  localparam int SW    = (WIN > 2) ? $clog2(WIN - 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          sdram_rd_req,
  input  logic          sdram_rd_valid,
  output logic          sram_en,
  output logic          sram_rd,
  output logic [SW-1:0] sram_slot,
  input  logic          sram_rd_valid,
  output logic          wb_en,
  output logic [1:0]    wb_mode,
  output logic [SW-1:0] wb_row,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          out_req,
  input  logic          out_ack,
  output logic          busy,
  output logic          done
);

  localparam int             SLOTS      = WIN - 1;
  localparam logic [RW-1:0]  ROW_CACHED = RW'(WIN - 1);
  localparam logic [CW-1:0]  COL_EMIT   = CW'(WIN - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] k, base, base_nxt, k_d, slot_d;
  logic [RW-1:0] row_adv;
  logic          col_last, row_last, k_last, accept, adv;
  wb_mode_t      wb_mode_d;

  assign accept  = (state == ST_IDLE) && start;
  assign adv     = (state == ST_ADV);
  assign row_adv = col_last ? row + 1'b1 : row;

  flex_counter #(.W(CW), .MAX(IMG_W - 1)) u_col (
    .clk(clk), .rst(rst), .en(adv), .clear(accept), .count(col), .rollover(col_last)
  );

  flex_counter #(.W(RW), .MAX(IMG_H - 1)) u_row (
    .clk(clk), .rst(rst), .en(adv && col_last), .clear(accept), .count(row), .rollover(row_last)
  );

  flex_counter #(.W(SW), .MAX(WIN - 2)) u_k (
    .clk(clk), .rst(rst), .en(state == ST_C_LOAD), .clear(accept), .count(k), .rollover(k_last)
  );

  // The oldest cached row is retired once per completed row outside the fill phase.
  always_comb begin
    base_nxt = base;
    if (accept) begin
      base_nxt = '0;
    end else if (adv && col_last && row >= ROW_CACHED) begin
      base_nxt = SW'(wrap_add(int'(base), 1, SLOTS));
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_FILL_REQ;
      ST_FILL_REQ:  state_nxt = ST_FILL_WAIT;
      ST_FILL_WAIT: if (sdram_rd_valid) state_nxt = ST_FILL_WR;
      ST_FILL_WR:   state_nxt = ST_ADV;
      ST_C_RD:      state_nxt = ST_C_WAIT;
      ST_C_WAIT:    if (sram_rd_valid) state_nxt = ST_C_LOAD;
      ST_C_LOAD:    state_nxt = k_last ? ST_SD_REQ : ST_C_RD;
      ST_SD_REQ:    state_nxt = ST_SD_WAIT;
      ST_SD_WAIT:   if (sdram_rd_valid) state_nxt = ST_SD_LOAD;
      ST_SD_LOAD:   state_nxt = ST_SHIFT;
      ST_SHIFT:     state_nxt = (col >= COL_EMIT) ? ST_EMIT : ST_ADV;
      ST_EMIT:      if (out_ack) state_nxt = ST_ADV;
      ST_ADV: begin
        if (col_last && row_last)      state_nxt = ST_DONE;
        else if (row_adv < ROW_CACHED) state_nxt = ST_FILL_REQ;
        else                           state_nxt = ST_C_RD;
      end
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    k_d       = (state == ST_C_LOAD) ? k + 1'b1 : k;
    slot_d    = '0;
    wb_mode_d = WB_LOAD_CACHE;
    case (state_nxt)
      ST_FILL_WR: slot_d = SW'(wrap_add(int'(base_nxt), int'(row), SLOTS));
      ST_C_RD:    slot_d = SW'(wrap_add(int'(base_nxt), int'(k_d), SLOTS));
      ST_SD_LOAD: slot_d = base_nxt;
      default:    slot_d = '0;
    endcase
    if (state_nxt == ST_SD_LOAD) wb_mode_d = WB_LOAD_SD;
    else if (state_nxt == ST_SHIFT) wb_mode_d = WB_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      base         <= '0;
      sdram_rd_req <= 1'b0;
      sram_en      <= 1'b0;
      sram_rd      <= 1'b0;
      sram_slot    <= '0;
      wb_en        <= 1'b0;
      wb_mode      <= WB_LOAD_CACHE;
      wb_row       <= '0;
      out_req      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      base         <= base_nxt;
      sdram_rd_req <= state_nxt inside {ST_FILL_REQ, ST_SD_REQ};
      sram_en      <= state_nxt inside {ST_FILL_WR, ST_C_RD, ST_SD_LOAD};
      sram_rd      <= (state_nxt == ST_C_RD);
      sram_slot    <= slot_d;
      wb_en        <= state_nxt inside {ST_C_LOAD, ST_SD_LOAD, ST_SHIFT};
      wb_mode      <= wb_mode_d;
      wb_row       <= (state_nxt == ST_C_LOAD) ? k : '0;
      out_req      <= (state_nxt == ST_EMIT);
      busy         <= (state_nxt != ST_IDLE);
      done         <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_window_sequencer.sv
// Self-checking bench: a transaction-level frame model predicts the ordered
// strobe stream; randomised responders and consumer exercise wait/hold paths.
module tb_window_sequencer;

  localparam int TW  = 4;
  localparam int TH  = 5;
  localparam int TWN = 3;
  localparam int CW  = $clog2(TW);
  localparam int RW  = $clog2(TH);
  localparam int SW  = (TWN > 2) ? $clog2(TWN - 1) : 1;

  logic          clk, rst, start;
  logic          sdram_rd_req, sdram_rd_valid;
  logic          sram_en, sram_rd, sram_rd_valid;
  logic [SW-1:0] sram_slot, wb_row;
  logic          wb_en;
  logic [1:0]    wb_mode;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          out_req, out_ack, busy, done;

  window_sequencer #(.IMG_W(TW), .IMG_H(TH), .WIN(TWN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_valid(sdram_rd_valid),
    .sram_en(sram_en), .sram_rd(sram_rd), .sram_slot(sram_slot), .sram_rd_valid(sram_rd_valid),
    .wb_en(wb_en), .wb_mode(wb_mode), .wb_row(wb_row),
    .col(col), .row(row), .out_req(out_req), .out_ack(out_ack),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sd_req;
    logic       sram_en;
    logic       sram_rd;
    logic [1:0] slot;
    logic       wb_en;
    logic [1:0] wb_mode;
    logic [1:0] wb_row;
    logic       emit;
    logic       done;
    logic [7:0] row;
    logic [7:0] col;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp, n_bad;
  int  n_sd, n_emit, n_done, n_ev;
  int  dut_wr_slot[TH];
  int  sd_max, sr_max, ack_mode, hold_cnt;
  bit  fixed_dly, noise_en;

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  function automatic string ev_str(input ev_t e);
    return $sformatf("{sd=%0b sram=%0b rd=%0b slot=%0d wb=%0b mode=%0d wrow=%0d emit=%0b done=%0b r%0d c%0d}",
                     e.sd_req, e.sram_en, e.sram_rd, e.slot, e.wb_en, e.wb_mode, e.wb_row,
                     e.emit, e.done, e.row, e.col);
  endfunction

  function automatic ev_t at(input int r, input int c);
    ev_t e;
    e = '0;
    e.row = 8'(r);
    e.col = 8'(c);
    return e;
  endfunction

  // Expected strobe stream for one frame, straight from the raster/window rules.
  task automatic build_frame();
    ev_t e;
    int  base;
    exp_q.delete();
    for (int r = 0; r < TH; r++) begin
      base = (r >= TWN - 1) ? (r - (TWN - 1)) % (TWN - 1) : 0;
      for (int c = 0; c < TW; c++) begin
        if (r < TWN - 1) begin
          e = at(r, c); e.sd_req = 1'b1; exp_q.push_back(e);
          e = at(r, c); e.sram_en = 1'b1; e.slot = 2'(r); exp_q.push_back(e);
        end else begin
          for (int k = 0; k < TWN - 1; k++) begin
            e = at(r, c); e.sram_en = 1'b1; e.sram_rd = 1'b1; e.slot = 2'((base + k) % (TWN - 1));
            exp_q.push_back(e);
            e = at(r, c); e.wb_en = 1'b1; e.wb_mode = 2'd0; e.wb_row = 2'(k); exp_q.push_back(e);
          end
          e = at(r, c); e.sd_req = 1'b1; exp_q.push_back(e);
          e = at(r, c); e.sram_en = 1'b1; e.slot = 2'(base); e.wb_en = 1'b1; e.wb_mode = 2'd1;
          exp_q.push_back(e);
          e = at(r, c); e.wb_en = 1'b1; e.wb_mode = 2'd2; exp_q.push_back(e);
          if (c >= TWN - 1) begin
            e = at(r, c); e.emit = 1'b1; exp_q.push_back(e);
          end
        end
      end
    end
    e = '0; e.done = 1'b1; exp_q.push_back(e);
  endtask

  // Responders and consumer: act at posedge+1 so inputs are stable around the next edge.
  initial begin
    int sd_cnt, sr_cnt;
    sd_cnt = -1; sr_cnt = -1;
    sdram_rd_valid = 1'b0; sram_rd_valid = 1'b0; out_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      sdram_rd_valid = 1'b0;
      sram_rd_valid  = 1'b0;
      if (rst) begin
        sd_cnt = -1; sr_cnt = -1;
      end else begin
        if (sd_cnt == 0) begin sdram_rd_valid = 1'b1; sd_cnt = -1; end
        else if (sd_cnt > 0) sd_cnt--;
        if (sr_cnt == 0) begin sram_rd_valid = 1'b1; sr_cnt = -1; end
        else if (sr_cnt > 0) sr_cnt--;
        if (sdram_rd_req) sd_cnt = fixed_dly ? sd_max : int'($urandom_range(sd_max, 0));
        else if (noise_en && sd_cnt < 0 && !sdram_rd_valid && ($urandom % 6 == 0)) sdram_rd_valid = 1'b1;
        if (sram_en && sram_rd) sr_cnt = fixed_dly ? sr_max : int'($urandom_range(sr_max, 0));
        else if (noise_en && sr_cnt < 0 && !sram_rd_valid && ($urandom % 6 == 0)) sram_rd_valid = 1'b1;
      end
      if (hold_cnt > 0) begin
        out_ack = 1'b0;
        if (out_req) hold_cnt--;
      end else begin
        out_ack = (ack_mode == 1) ? ($urandom % 3 == 0) : 1'b1;
      end
    end
  end

  // Compare process: every cycle with any strobe or accepted window is one ordered event.
  always @(negedge clk) begin
    ev_t o, e;
    if (!rst && (sdram_rd_req || sram_en || wb_en || done || (out_req && out_ack))) begin
      o = '0;
      o.sd_req = sdram_rd_req;
      if (sram_en) begin
        o.sram_en = 1'b1; o.sram_rd = sram_rd; o.slot = 2'(sram_slot);
      end
      if (wb_en) begin
        o.wb_en = 1'b1; o.wb_mode = wb_mode;
        if (wb_mode == 2'd0) o.wb_row = 2'(wb_row);
      end
      o.emit = out_req && out_ack;
      o.done = done;
      if (!done) begin o.row = 8'(row); o.col = 8'(col); end
      if (sdram_rd_req) n_sd++;
      if (o.emit) n_emit++;
      if (done) begin
        n_done++;
        check("busy_at_done", busy == 1'b1, $sformatf("%0b", busy), "1");
      end
      if (sram_en && !sram_rd && int'(row) < TH) dut_wr_slot[row] = int'(sram_slot);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1'b0, ev_str(o), "no activity");
      end else begin
        e = exp_q.pop_front();
        check($sformatf("event%0d", n_ev), o == e, ev_str(o), ev_str(e));
      end
      n_ev++;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobes"}, {sdram_rd_req, sram_en, wb_en, done} == 4'b0,
          $sformatf("%b", {sdram_rd_req, sram_en, wb_en, done}), "0000");
    check({tag, "_sram"}, {sram_rd, sram_slot} == '0, $sformatf("%0b/%0d", sram_rd, sram_slot), "0/0");
    check({tag, "_wb"}, {wb_mode, wb_row} == '0, $sformatf("%0d/%0d", wb_mode, wb_row), "0/0");
    check({tag, "_pos"}, {col, row} == '0, $sformatf("r%0d c%0d", row, col), "r0 c0");
    check({tag, "_req_busy"}, {out_req, busy} == 2'b0, $sformatf("%b", {out_req, busy}), "00");
  endtask

  task automatic run_frame(input string tag, input int sdm, input int srm, input bit fixd,
                           input int amode, input bit hold, input bit snoise);
    int cyc;
    sd_max = sdm; sr_max = srm; fixed_dly = fixd; ack_mode = amode;
    noise_en = snoise; hold_cnt = hold ? 10 : 0;
    build_frame();
    n_sd = 0; n_emit = 0; n_done = 0;
    for (int i = 0; i < TH; i++) dut_wr_slot[i] = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (hold) begin
      int hr, hc;
      cyc = 0;
      while (!out_req && cyc < 3000) begin @(negedge clk); cyc++; end
      check({tag, "_first_emit_seen"}, out_req == 1'b1, $sformatf("%0b", out_req), "1");
      hr = int'(row); hc = int'(col);
      check({tag, "_first_emit_pos"}, hr == 2 && hc == 2, $sformatf("r%0d c%0d", hr, hc), "r2 c2");
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({tag, "_hold"}, out_req && !sdram_rd_req && int'(row) == hr && int'(col) == hc,
              $sformatf("req=%0b sd=%0b r%0d c%0d", out_req, sdram_rd_req, row, col),
              $sformatf("req=1 sd=0 r%0d c%0d", hr, hc));
      end
    end
    cyc = 0;
    while ((n_done == 0 || exp_q.size() != 0) && cyc < 4000) begin
      @(posedge clk); #1;
      start = snoise && n_done == 0 && !done && ($urandom % 10 == 0);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_finished"}, cyc < 4000, $sformatf("%0d cycles", cyc), "< 4000 cycles");
    check({tag, "_sdram_reads"}, n_sd == 20, $sformatf("%0d", n_sd), "20");
    check({tag, "_emits"}, n_emit == 6, $sformatf("%0d", n_emit), "6");
    check({tag, "_dones"}, n_done == 1, $sformatf("%0d", n_done), "1");
    check({tag, "_slots"}, dut_wr_slot[0] == 0 && dut_wr_slot[1] == 1 && dut_wr_slot[2] == 0 &&
          dut_wr_slot[3] == 1 && dut_wr_slot[4] == 0,
          $sformatf("%0d %0d %0d %0d %0d", dut_wr_slot[0], dut_wr_slot[1], dut_wr_slot[2],
                    dut_wr_slot[3], dut_wr_slot[4]), "0 1 0 1 0");
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_after"}, !busy && !done, $sformatf("busy=%0b done=%0b", busy, done), "busy=0 done=0");
  endtask

  initial begin
    int cyc;
    n_cmp = 0; n_bad = 0; n_ev = 0;
    sd_max = 0; sr_max = 0; fixed_dly = 1'b1; ack_mode = 0; hold_cnt = 0; noise_en = 1'b0;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    exp_q.delete();

    run_frame("zero_wait", 0, 0, 1'b1, 0, 1'b0, 1'b0);
    run_frame("slow_resp", 5, 3, 1'b1, 0, 1'b0, 1'b0);
    run_frame("ack_hold", 2, 1, 1'b0, 0, 1'b1, 1'b0);
    run_frame("random", 5, 3, 1'b0, 1, 1'b0, 1'b1);

    // Abort a frame while it waits for the first SDRAM pixel of row 2.
    sd_max = 5; sr_max = 0; fixed_dly = 1'b1; ack_mode = 0; noise_en = 1'b0;
    build_frame();
    n_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(sdram_rd_req && int'(row) == 2) && cyc < 3000) begin @(negedge clk); cyc++; end
    check("abort_reached_row2", sdram_rd_req && int'(row) == 2,
          $sformatf("sd=%0b r%0d", sdram_rd_req, row), "sd=1 r2");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("abort");
    rst = 1'b0;
    exp_q.delete();
    noise_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", n_done == 0, $sformatf("%0d", n_done), "0");
    check("abort_idle", !busy, $sformatf("%0b", busy), "0");
    noise_en = 1'b0;

    run_frame("after_abort", 4, 3, 1'b0, 1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
